// File: rtl/lift_req_queue.sv
// Hall-call request queue for the lift controller.
// Rising edges on the six hall-call buttons are de-duplicated against calls
// already registered (lamp lit), parked in an arrival register, and moved
// one per cycle, lowest index first, into a circular FIFO. The FIFO head is
// presented on din and retired on every clock edge where done is high.
// All outputs come straight from flops. din and qEmpty are precomputed from
// next-state values so that they reflect the queue contents after each edge.

module lift_req_queue #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [5:0]               btn,
    input  logic                     done,
    output logic [2:0]               din,
    output logic                     qEmpty,
    output logic [5:0]               lamp,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] ZERO_CNT = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);
    localparam logic [PW-1:0] ONE_PTR  = PW'(1);

    // Button index to request code: 1U 2U 3U 2D 3D 4D.
    function automatic logic [2:0] code_of(input logic [2:0] idx);
        logic [2:0] code;
        case (idx)
            3'd0:    code = 3'b001;
            3'd1:    code = 3'b010;
            3'd2:    code = 3'b011;
            3'd3:    code = 3'b110;
            3'd4:    code = 3'b111;
            3'd5:    code = 3'b100;
            default: code = 3'b000;
        endcase
        return code;
    endfunction

    // Request code back to a one-hot button mask (zero for NONE or unused codes).
    function automatic logic [5:0] onehot_of_code(input logic [2:0] code);
        logic [5:0] oh;
        case (code)
            3'b001:  oh = 6'b000001;
            3'b010:  oh = 6'b000010;
            3'b011:  oh = 6'b000100;
            3'b110:  oh = 6'b001000;
            3'b111:  oh = 6'b010000;
            3'b100:  oh = 6'b100000;
            default: oh = 6'b000000;
        endcase
        return oh;
    endfunction

    logic [5:0]    btn_q_r;
    logic [5:0]    arr_r;
    logic [5:0]    lamp_r;
    logic [PW-1:0] head_r;
    logic [PW-1:0] tail_r;
    logic [CW-1:0] count_r;
    logic [2:0]    din_r;
    logic          qempty_r;
    logic [2:0]    mem_r [DEPTH];

    logic [5:0]    rise_s;
    logic          pop_s;
    logic [5:0]    pop_oh_s;
    logic [5:0]    accept_s;
    logic          arr_found_s;
    logic [2:0]    enq_idx_s;
    logic          enq_s;
    logic [2:0]    enq_code_s;
    logic [5:0]    enq_oh_s;
    logic [5:0]    arr_nxt_s;
    logic [5:0]    lamp_nxt_s;
    logic [PW-1:0] head_nxt_s;
    logic [PW-1:0] tail_nxt_s;
    logic [CW-1:0] count_nxt_s;
    logic [2:0]    din_nxt_s;

    // Next-state logic: edge detect, de-dup, pop, single enqueue, output precompute.
    always_comb begin
        rise_s      = btn & ~btn_q_r;
        pop_s       = done & (count_r != ZERO_CNT);
        pop_oh_s    = 6'b000000;
        arr_found_s = 1'b0;
        enq_idx_s   = 3'd0;
        enq_oh_s    = 6'b000000;
        count_nxt_s = count_r;
        din_nxt_s   = 3'b000;

        if (pop_s) begin
            pop_oh_s = onehot_of_code(mem_r[head_r]);
        end else begin
            pop_oh_s = 6'b000000;
        end

        // A lit lamp blocks a new press unless that very call is leaving now.
        accept_s = rise_s & (~lamp_r | pop_oh_s);

        for (int i = 0; i < 6; i++) begin
            if (arr_r[i] && !arr_found_s) begin
                enq_idx_s   = 3'(i);
                arr_found_s = 1'b1;
            end else begin
                arr_found_s = arr_found_s;
            end
        end

        enq_s      = arr_found_s & ((count_r != FULL_CNT) | pop_s);
        enq_code_s = code_of(enq_idx_s);

        if (enq_s) begin
            enq_oh_s = 6'b000001 << enq_idx_s;
        end else begin
            enq_oh_s = 6'b000000;
        end

        arr_nxt_s  = (arr_r & ~enq_oh_s) | accept_s;
        lamp_nxt_s = (lamp_r & ~pop_oh_s) | accept_s;

        if (pop_s) begin
            head_nxt_s = head_r + ONE_PTR;
        end else begin
            head_nxt_s = head_r;
        end

        if (enq_s) begin
            tail_nxt_s = tail_r + ONE_PTR;
        end else begin
            tail_nxt_s = tail_r;
        end

        case ({enq_s, pop_s})
            2'b10:   count_nxt_s = count_r + ONE_CNT;
            2'b01:   count_nxt_s = count_r - ONE_CNT;
            default: count_nxt_s = count_r;
        endcase

        // When the surviving entries end exactly at the old tail, the entry
        // being written this cycle is the new head and is not in mem_r yet.
        if (count_nxt_s == ZERO_CNT) begin
            din_nxt_s = 3'b000;
        end else if (enq_s && (head_nxt_s == tail_r)) begin
            din_nxt_s = enq_code_s;
        end else begin
            din_nxt_s = mem_r[head_nxt_s];
        end
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_q_r  <= 6'b000000;
            arr_r    <= 6'b000000;
            lamp_r   <= 6'b000000;
            head_r   <= {PW{1'b0}};
            tail_r   <= {PW{1'b0}};
            count_r  <= ZERO_CNT;
            din_r    <= 3'b000;
            qempty_r <= 1'b1;
        end else begin
            btn_q_r  <= btn;
            arr_r    <= arr_nxt_s;
            lamp_r   <= lamp_nxt_s;
            head_r   <= head_nxt_s;
            tail_r   <= tail_nxt_s;
            count_r  <= count_nxt_s;
            din_r    <= din_nxt_s;
            qempty_r <= (count_nxt_s == ZERO_CNT);
        end
    end

    // FIFO storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (rst_n && enq_s) begin
            mem_r[tail_r] <= enq_code_s;
        end
    end

    assign din    = din_r;
    assign qEmpty = qempty_r;
    assign lamp   = lamp_r;
    assign count  = count_r;

endmodule

// File: tb/tb_lift_req_queue.sv
// Directed bench for lift_req_queue: one DEPTH=8 instance for normal
// operation and one DEPTH=2 instance for the full/backpressure case.

module tb_lift_req_queue;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] btn, btn2;
    logic       done, done2;
    logic [2:0] din, din2;
    logic       qEmpty, qEmpty2;
    logic [5:0] lamp, lamp2;
    logic [3:0] count;
    logic [1:0] count2;

    int n_cmp = 0;
    int n_err = 0;

    lift_req_queue #(.DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .btn(btn), .done(done),
        .din(din), .qEmpty(qEmpty), .lamp(lamp), .count(count)
    );

    lift_req_queue #(.DEPTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .btn(btn2), .done(done2),
        .din(din2), .qEmpty(qEmpty2), .lamp(lamp2), .count(count2)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; btn = 6'b000100; done = 1'b0; btn2 = 6'b000000; done2 = 1'b0;
        tick(); tick();
        n_cmp++; if (din !== 3'b000) begin n_err++; $display("FAIL reset_din got %b want 000", din); end
        n_cmp++; if (qEmpty !== 1'b1) begin n_err++; $display("FAIL reset_qempty got %b want 1", qEmpty); end
        n_cmp++; if (lamp !== 6'b000000) begin n_err++; $display("FAIL reset_lamp got %b want 000000", lamp); end
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
        n_cmp++; if (count2 !== 2'd0 || qEmpty2 !== 1'b1) begin n_err++; $display("FAIL reset_dut2 got count %0d qEmpty %b want 0 1", count2, qEmpty2); end
        rst_n = 1'b1;
        tick();
        n_cmp++; if (lamp !== 6'b000100) begin n_err++; $display("FAIL held_lamp got %b want 000100", lamp); end
        n_cmp++; if (din !== 3'b000) begin n_err++; $display("FAIL held_din_early got %b want 000", din); end
        tick();
        n_cmp++; if (din !== 3'b011) begin n_err++; $display("FAIL held_din got %b want 011", din); end
        n_cmp++; if (count !== 4'd1) begin n_err++; $display("FAIL held_count got %0d want 1", count); end
        btn = 6'b000000; done = 1'b1;
        tick();
        done = 1'b0;
        n_cmp++; if (qEmpty !== 1'b1 || lamp !== 6'b000000) begin n_err++; $display("FAIL held_drain got qEmpty %b lamp %b want 1 000000", qEmpty, lamp); end
    endtask

    task automatic test_single();
        btn = 6'b100000; tick();
        btn = 6'b000000; tick();
        n_cmp++; if (din !== 3'b100) begin n_err++; $display("FAIL single_din got %b want 100", din); end
        n_cmp++; if (qEmpty !== 1'b0) begin n_err++; $display("FAIL single_qempty got %b want 0", qEmpty); end
        n_cmp++; if (count !== 4'd1) begin n_err++; $display("FAIL single_count got %0d want 1", count); end
        done = 1'b1; tick(); done = 1'b0;
        n_cmp++; if (din !== 3'b000) begin n_err++; $display("FAIL single_pop_din got %b want 000", din); end
        n_cmp++; if (qEmpty !== 1'b1) begin n_err++; $display("FAIL single_pop_qempty got %b want 1", qEmpty); end
        n_cmp++; if (lamp !== 6'b000000) begin n_err++; $display("FAIL single_pop_lamp got %b want 000000", lamp); end
    endtask

    task automatic test_dedupe();
        btn = 6'b001000; tick();
        btn = 6'b000000; tick();
        btn = 6'b001000; tick();
        btn = 6'b000000; tick(); tick(); tick();
        n_cmp++; if (count !== 4'd1) begin n_err++; $display("FAIL dedupe_count got %0d want 1", count); end
        n_cmp++; if (lamp !== 6'b001000) begin n_err++; $display("FAIL dedupe_lamp got %b want 001000", lamp); end
        n_cmp++; if (din !== 3'b110) begin n_err++; $display("FAIL dedupe_din got %b want 110", din); end
        done = 1'b1; tick(); done = 1'b0;
        n_cmp++; if (count !== 4'd0 || qEmpty !== 1'b1) begin n_err++; $display("FAIL dedupe_drain got count %0d qEmpty %b want 0 1", count, qEmpty); end
    endtask

    task automatic test_simultaneous();
        btn = 6'b101010; tick();
        btn = 6'b000000;
        n_cmp++; if (lamp !== 6'b101010) begin n_err++; $display("FAIL simul_lamp got %b want 101010", lamp); end
        tick();
        n_cmp++; if (count !== 4'd1 || din !== 3'b010) begin n_err++; $display("FAIL simul_first got count %0d din %b want 1 010", count, din); end
        tick(); tick(); tick();
        n_cmp++; if (count !== 4'd3) begin n_err++; $display("FAIL simul_peak got %0d want 3", count); end
        done = 1'b1;
        tick();
        n_cmp++; if (din !== 3'b110 || count !== 4'd2) begin n_err++; $display("FAIL simul_pop1 got din %b count %0d want 110 2", din, count); end
        tick();
        n_cmp++; if (din !== 3'b100) begin n_err++; $display("FAIL simul_pop2 got %b want 100", din); end
        tick();
        done = 1'b0;
        n_cmp++; if (din !== 3'b000 || qEmpty !== 1'b1 || lamp !== 6'b000000) begin n_err++; $display("FAIL simul_pop3 got din %b qEmpty %b lamp %b want 000 1 000000", din, qEmpty, lamp); end
    endtask

    task automatic test_done_low_holds();
        btn = 6'b000001; tick();
        btn = 6'b010000; tick();
        btn = 6'b000000;
        for (int i = 0; i < 10; i++) tick();
        n_cmp++; if (din !== 3'b001) begin n_err++; $display("FAIL hold_din got %b want 001", din); end
        n_cmp++; if (count !== 4'd2) begin n_err++; $display("FAIL hold_count got %0d want 2", count); end
        done = 1'b1; tick();
        n_cmp++; if (din !== 3'b111) begin n_err++; $display("FAIL hold_pop1 got %b want 111", din); end
        tick(); done = 1'b0;
        n_cmp++; if (din !== 3'b000 || qEmpty !== 1'b1) begin n_err++; $display("FAIL hold_pop2 got din %b qEmpty %b want 000 1", din, qEmpty); end
    endtask

    task automatic test_pop_press_same_cycle();
        btn = 6'b000100; tick();
        btn = 6'b000000; tick();
        btn = 6'b100000; tick();
        btn = 6'b000100; done = 1'b1; tick();
        btn = 6'b000000; done = 1'b0;
        n_cmp++; if (count !== 4'd1) begin n_err++; $display("FAIL popress_count got %0d want 1", count); end
        n_cmp++; if (din !== 3'b100) begin n_err++; $display("FAIL popress_din got %b want 100", din); end
        n_cmp++; if (lamp !== 6'b100100) begin n_err++; $display("FAIL popress_lamp got %b want 100100", lamp); end
        tick();
        n_cmp++; if (count !== 4'd2) begin n_err++; $display("FAIL popress_requeue got %0d want 2", count); end
        done = 1'b1; tick();
        n_cmp++; if (din !== 3'b011 || lamp !== 6'b000100) begin n_err++; $display("FAIL popress_pop1 got din %b lamp %b want 011 000100", din, lamp); end
        tick(); done = 1'b0;
        n_cmp++; if (qEmpty !== 1'b1 || lamp !== 6'b000000) begin n_err++; $display("FAIL popress_pop2 got qEmpty %b lamp %b want 1 000000", qEmpty, lamp); end
    endtask

    task automatic test_full_depth2();
        logic [2:0] exp_seq [6];
        exp_seq[0] = 3'b010; exp_seq[1] = 3'b011; exp_seq[2] = 3'b110;
        exp_seq[3] = 3'b111; exp_seq[4] = 3'b100; exp_seq[5] = 3'b000;
        btn2 = 6'b000011; tick();
        btn2 = 6'b000000; tick(); tick();
        btn2 = 6'b111100; tick();
        btn2 = 6'b000000; tick(); tick(); tick();
        n_cmp++; if (count2 !== 2'd2) begin n_err++; $display("FAIL full_count got %0d want 2", count2); end
        n_cmp++; if (din2 !== 3'b001) begin n_err++; $display("FAIL full_head got %b want 001", din2); end
        n_cmp++; if (lamp2 !== 6'b111111) begin n_err++; $display("FAIL full_lamp got %b want 111111", lamp2); end
        done2 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_cmp++; if (din2 !== exp_seq[i]) begin n_err++; $display("FAIL full_drain_%0d got %b want %b", i, din2, exp_seq[i]); end
        end
        done2 = 1'b0;
        n_cmp++; if (qEmpty2 !== 1'b1 || lamp2 !== 6'b000000) begin n_err++; $display("FAIL full_end got qEmpty %b lamp %b want 1 000000", qEmpty2, lamp2); end
    endtask

    task automatic test_reset_mid_operation();
        btn = 6'b000011; tick();
        btn = 6'b000000; tick();
        rst_n = 1'b0; tick();
        n_cmp++; if (count !== 4'd0 || lamp !== 6'b000000 || din !== 3'b000) begin n_err++; $display("FAIL midrst_state got count %0d lamp %b din %b want 0 000000 000", count, lamp, din); end
        rst_n = 1'b1; tick(); tick();
        n_cmp++; if (count !== 4'd0 || qEmpty !== 1'b1) begin n_err++; $display("FAIL midrst_after got count %0d qEmpty %b want 0 1", count, qEmpty); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_dedupe();
        test_simultaneous();
        test_done_low_holds();
        test_pop_press_same_cycle();
        test_full_depth2();
        test_reset_mid_operation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lift_req_queue.md
# lift_req_queue

Hall-call request queue feeding the lift controller FSM. Captures six hall-call buttons and de-duplicates them against calls already pending. Stores accepted calls in arrival order in a circular FIFO and presents the head on `din` with `qEmpty`. The head is retired each cycle the lift controller signals `done`, i.e. the controller is idle and consuming `din`.

## Interface
- `DEPTH`, 8, FIFO entries; power of 2, ≥2 (≥6 guarantees no blocking)
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  reset, synchronous, active-low; clock clk
- `btn`  in  6  hall-call buttons, level: [0]=1U [1]=2U [2]=3U [3]=2D [4]=3D [5]=4D
- `done`  in  1  lift controller idle/ready; head consumed at every edge where done=1 and qEmpty=0
- `din`  out  3  head request code: 1U=001 2U=010 3U=011 2D=110 3D=111 4D=100; 000 (NONE) when empty
- `qEmpty`  out  1  1 when FIFO holds no entries
- `lamp`  out  6  per-button "call registered" indicator, same bit order as btn
- `count`  out  clog2(DEPTH)+1  FIFO occupancy

## Operation
- Edge detect: `btn_q <= btn` each cycle; `rise = btn & ~btn_q`. Held button yields one request only.
- Accept: rise[i] accepted iff lamp[i]=0, or the entry popped this same cycle has code i. Otherwise dropped.
- Accepted rise sets `arr[i]` (arrival register) and `lamp[i]` at that edge.
- Enqueue: each cycle, if arr≠0 and FIFO not full (or popping this cycle), the lowest-index set arr bit is written at tail as its code, then cleared from arr. One enqueue per cycle max.
- Pop: at edge with done=1 and count≠0, head pointer advances. lamp[code of popped entry] clears, unless re-accepted the same cycle (then stays 1).
- Pop and enqueue in the same cycle: count unchanged; pointers both advance.
- Full with arr≠0: arr bits wait. No loss, no overwrite. Only reachable with DEPTH<6.
- Pointers are clog2(DEPTH)-bit, wrapping modulo DEPTH. Full/empty are derived from count.
- din and qEmpty are registered-state driven: din = mem[head] when count≠0, else 000. qEmpty = (count==0).
- done is sampled only. The queue never waits on a done edge; a done pulse of N cycles retires up to N entries.

## Timing
- Reset (rst_n=0 at an edge): count=0, head=tail=0, arr=0, lamp=0, btn_q=0, din=000, qEmpty=1. Mem contents don't care.
- A button held through reset registers once, on the first edge after rst_n=1.
- Latency: btn rises before edge E0 → lamp=1 and arr set after E0. Entry written at E1. din/qEmpty valid after E1, so 2 cycles, press to visible.
- Pop latency: with done=1 at edge Ek, the next entry (or 000/qEmpty=1) appears after Ek. The lamp clears after Ek.
- Reset mid-operation discards all queued and arriving calls. All outputs take reset values after that edge.
- Multiple simultaneous rises enqueue in index order, 1U first, on consecutive cycles.

## Test plan
- Reset: hold rst_n=0 two cycles with btn=6'b000100 → din=000, qEmpty=1, lamp=0, count=0. After release, one 3U entry appears 2 edges later: din=011, lamp=000100.
- Single call: done=0, pulse btn[5] one cycle → after 2 edges din=100, qEmpty=0, count=1. Set done=1 for one edge → din=000, qEmpty=1, lamp=0.
- Dedupe: done=0, press 2D, release, press 2D again → count=1, lamp[3]=1. A second 2D entry is never produced.
- Simultaneous: done=0, btn=6'b101010 in one cycle → din sequence on successive pops 010, 110, 100; count peaks at 3.
- done low holds head: queue 1U then 3D, keep done=0 for 10 cycles → din stays 001, count=2. Raise done two edges → 111 then 000.
- Pop+press same cycle: head=3U, done=1, and a 3U rise at the same edge → count unchanged, lamp[2] stays 1, new 3U at tail. With DEPTH=2, fill 2 entries plus 4 simultaneous rises and done=0 → count=2, no overwrite. Then done=1 drains all six in index order.
